// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel registered stream multiplexer with a built-in
// arbiter. Producers present words with valid/ready; one channel is granted
// per cycle and its word is captured into a single output register that
// drains to the consumer through its own valid/ready pair.
//
// Handshake rule (all ports): a word moves on a rising clock edge exactly
// when valid and ready are both 1 in the cycle before that edge. A producer
// may withdraw valid at any time; ready never depends on a lock, it is
// re-evaluated every cycle from the current valid inputs.
module stream_mux_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    localparam int CHAN_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHAN_W-1:0]    out_chan,
    input  logic                 out_ready
);

    // Output register and round-robin pointer (last granted channel).
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [CHAN_W-1:0]   r_out_chan;
    logic [CHAN_W-1:0]   r_ptr;

    // Arbitration results for the current cycle.
    logic                w_load_en;
    logic                w_any;
    logic [CHAN_W-1:0]   w_grant_idx;
    logic [N-1:0]        w_grant;
    logic [WIDTH-1:0]    w_sel_data;

    // The output register can take a new word when it is empty or when its
    // current word leaves this cycle; this is what allows one word per clock.
    always_comb begin
        w_load_en = ~r_out_valid | out_ready;
    end

    // Priority search. Round-robin starts just after the last granted
    // channel and wraps; fixed priority always starts at channel 0.
    always_comb begin
        logic [CHAN_W-1:0] w_cand;
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int s = 0; s < N; s++) begin
            if (MODE == 1) begin
                w_cand = CHAN_W'(s);
            end else begin
                w_cand = CHAN_W'((int'(r_ptr) + 1 + s) % N);
            end
            if (!w_any && in_valid[w_cand]) begin
                w_any       = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // One-hot grant vector and the granted channel's data word.
    always_comb begin
        w_grant    = '0;
        w_sel_data = '0;
        if (w_any) begin
            w_grant = N'(1) << w_grant_idx;
        end
        for (int i = 0; i < N; i++) begin
            if (w_any && (w_grant_idx == CHAN_W'(i))) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready goes only to the granted channel, only when the output register
    // can load, and never while reset is held.
    always_comb begin
        in_ready = w_grant & {N{w_load_en}} & {N{~rst}};
    end

    // Output register and pointer: load on accept, empty when idle, hold on
    // stall. Reset discards any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= CHAN_W'(N - 1);
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_grant_idx;
                r_ptr       <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Drive the registered outputs.
    always_comb begin
        out_valid = r_out_valid;
        out_data  = r_out_data;
        out_chan  = r_out_chan;
    end

    // Structural sanity: at most one ready, and only toward a valid producer.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(in_ready));
            assert ((in_ready & ~in_valid) == '0);
        end
    end

endmodule
